// File: rtl/mem_fu_ctrl_pkg.sv
// Shared definitions for the memory functional-unit controller:
// FSM state encoding, RISC-V load/store funct3 codes, the load/store
// flag encoding shared with the issue queue, and the alignment helper.
package mem_fu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2,
        ST_DRAIN  = 2'd3
    } mem_fu_state_t;

    // funct3 encodings; loads and stores share the size field in bits [1:0]
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd4;
    localparam logic [2:0] MEM_LHU = 3'd5;
    localparam logic [2:0] MEM_SB  = 3'd0;
    localparam logic [2:0] MEM_SH  = 3'd1;
    localparam logic [2:0] MEM_SW  = 3'd2;

    // ls field as carried by the issue queue
    localparam logic IS_LOAD  = 1'b0;
    localparam logic IS_STORE = 1'b1;

    // Access size field (funct3[1:0]): 0 = byte, 1 = half, 2 = word
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    // True when the access does not fit naturally inside its aligned slot
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF)
            mis = off[0];
        else if (size != SZ_BYTE)
            mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_fu_ctrl_if.sv
// Bus bundle around the memory FU controller: issue-side request and
// flush, data-memory port, and CDB request/grant. The controller uses
// the slave view; the surrounding pipeline (or a bench) uses master.
interface mem_fu_ctrl_if #(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5
);
    logic                 flush;
    logic                 req_valid;
    logic                 req_ls;
    logic [2:0]           req_mem_op;
    logic [XLEN-1:0]      req_rs1;
    logic [XLEN-1:0]      req_rs2;
    logic [XLEN-1:0]      req_offset;
    logic [ROB_TAG_W-1:0] req_rob_tag;
    logic                 backpressure;

    logic [XLEN-1:0]      dmem_addr;
    logic [3:0]           dmem_rmask;
    logic [3:0]           dmem_wmask;
    logic [XLEN-1:0]      dmem_wdata;
    logic [XLEN-1:0]      dmem_rdata;
    logic                 dmem_resp;

    logic                 cdb_req;
    logic                 cdb_gnt;
    logic [ROB_TAG_W-1:0] cdb_rob_tag;
    logic [XLEN-1:0]      cdb_data;
    logic                 cdb_exc;

    modport master (
        output flush, req_valid, req_ls, req_mem_op, req_rs1, req_rs2,
               req_offset, req_rob_tag, dmem_rdata, dmem_resp, cdb_gnt,
        input  backpressure, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               cdb_req, cdb_rob_tag, cdb_data, cdb_exc
    );

    modport slave (
        input  flush, req_valid, req_ls, req_mem_op, req_rs1, req_rs2,
               req_offset, req_rob_tag, dmem_rdata, dmem_resp, cdb_gnt,
        output backpressure, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               cdb_req, cdb_rob_tag, cdb_data, cdb_exc
    );
endinterface

// File: rtl/mem_fu_ctrl_lane_align.sv
// mem_lane_align: purely combinational byte-lane logic for the memory FU.
// Request side builds the byte mask and lane-shifted store data from the
// access size and address offset; response side shifts the read word down
// and sign/zero-extends it according to the load funct3.
module mem_lane_align
    import mem_fu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            ls,
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      rmask,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_op,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_result
);

    // Sign- or zero-extend the low lane(s) of an already right-aligned word
    function automatic logic [XLEN-1:0] extend(input logic [2:0] op,
                                               input logic [XLEN-1:0] v);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [XLEN-1:0]    r;
        sb = v[7:0];
        sh = v[15:0];
        case (op)
            MEM_LB:  r = {{(XLEN-8){sb[7]}}, sb};
            MEM_LH:  r = {{(XLEN-16){sh[15]}}, sh};
            MEM_LBU: r = {{(XLEN-8){1'b0}}, v[7:0]};
            MEM_LHU: r = {{(XLEN-16){1'b0}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    logic [3:0]      mask;
    logic [XLEN-1:0] rd_shifted;

    // Request-side mask and store-data lane placement; oversize masks truncate to 4 bits
    always_comb begin
        case (size)
            2'd0:    mask = 4'b0001 << off;
            2'd1:    mask = 4'b0011 << off;
            default: mask = 4'b1111;
        endcase
        rmask = (ls == IS_LOAD)  ? mask : 4'b0000;
        wmask = (ls == IS_STORE) ? mask : 4'b0000;
        wdata = st_data << {off, 3'b000};
    end

    // Response-side lane extraction and extension
    always_comb begin
        rd_shifted = rdata >> {ld_off, 3'b000};
        ld_result  = extend(ld_op, rd_shifted);
    end

endmodule

// File: rtl/mem_fu_ctrl.sv
// mem_fu_ctrl: sequencing controller for the single memory functional unit.
// Accepts one issued load/store at a time, drives a registered data-memory
// request until the response, then offers the result on the CDB until
// granted. Flush drops the result; an in-flight access is drained first.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// bypass memory and report cdb_exc=1 with the effective address as data.
module mem_fu_ctrl
    import mem_fu_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_fu_ctrl_if.slave bus
);

    mem_fu_state_t        state, state_nxt;
    logic [XLEN-1:0]      ea;
    logic                 accept;
    logic                 trap;
    logic                 resp_done;

    // Packet fields held for the response side
    logic                 ls_p1;
    logic [2:0]           op_p1;
    logic [1:0]           off_p1;
    logic [ROB_TAG_W-1:0] tag_p1;

    // Registered memory request
    logic [XLEN-1:0]      addr_p1;
    logic [3:0]           rmask_p1;
    logic [3:0]           wmask_p1;
    logic [XLEN-1:0]      wdata_p1;

    // Result waiting for the CDB
    logic [XLEN-1:0]      result_p2;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 exc_p2;
`endif

    logic [3:0]           al_rmask;
    logic [3:0]           al_wmask;
    logic [XLEN-1:0]      al_wdata;
    logic [XLEN-1:0]      ld_result;

    assign ea        = bus.req_rs1 + bus.req_offset;
    assign accept    = (state == ST_IDLE) && bus.req_valid && !bus.flush;
    assign resp_done = bus.dmem_resp && ((state == ST_ACCESS) || (state == ST_DRAIN));

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(bus.req_mem_op[1:0], ea[1:0]);
`else
    assign trap = 1'b0;
`endif

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .ls        (bus.req_ls),
        .size      (bus.req_mem_op[1:0]),
        .off       (ea[1:0]),
        .st_data   (bus.req_rs2),
        .rmask     (al_rmask),
        .wmask     (al_wmask),
        .wdata     (al_wdata),
        .ld_op     (op_p1),
        .ld_off    (off_p1),
        .rdata     (bus.dmem_rdata),
        .ld_result (ld_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: flush in WB drops the result, flush in ACCESS drains the access
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = trap ? ST_WB : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.dmem_resp)  state_nxt = bus.flush ? ST_IDLE : ST_WB;
                else if (bus.flush) state_nxt = ST_DRAIN;
            end
            ST_WB: begin
                if (bus.flush || bus.cdb_gnt) state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.dmem_resp) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; CDB fields read as zero outside WB
    always_comb begin
        bus.backpressure = (state != ST_IDLE);
        bus.cdb_req      = (state == ST_WB);
        bus.cdb_rob_tag  = (state == ST_WB) ? tag_p1    : '0;
        bus.cdb_data     = (state == ST_WB) ? result_p2 : '0;
`ifdef MEM_MISALIGN_TRAP_EN
        bus.cdb_exc      = (state == ST_WB) && exc_p2;
`else
        bus.cdb_exc      = 1'b0;
`endif
    end

    // ---- stage p1: latch the accepted packet ----
    always_ff @(posedge clk) begin
        if (accept) begin
            ls_p1  <= bus.req_ls;
            op_p1  <= bus.req_mem_op;
            off_p1 <= ea[1:0];
            tag_p1 <= bus.req_rob_tag;
        end
    end

    // Memory request registers: load on accept, hold through the response cycle, then clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1  <= '0;
            rmask_p1 <= '0;
            wmask_p1 <= '0;
            wdata_p1 <= '0;
        end else if (accept && !trap) begin
            addr_p1  <= {ea[XLEN-1:2], 2'b00};
            rmask_p1 <= al_rmask;
            wmask_p1 <= al_wmask;
            wdata_p1 <= al_wdata;
        end else if (resp_done) begin
            addr_p1  <= '0;
            rmask_p1 <= '0;
            wmask_p1 <= '0;
            wdata_p1 <= '0;
        end
    end

    assign bus.dmem_addr  = addr_p1;
    assign bus.dmem_rmask = rmask_p1;
    assign bus.dmem_wmask = wmask_p1;
    assign bus.dmem_wdata = wdata_p1;

    // ---- stage p2: capture the CDB result ----
    always_ff @(posedge clk) begin
        if (accept && trap) begin
            result_p2 <= ea;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_p2    <= 1'b1;
`endif
        end else if ((state == ST_ACCESS) && bus.dmem_resp) begin
            result_p2 <= (ls_p1 == IS_STORE) ? '0 : ld_result;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_p2    <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_fu_ctrl.sv
// Scoreboard bench for mem_fu_ctrl: stimulus pushes expected memory and
// CDB transactions into queues, a negedge monitor pops and compares them.
module tb_mem_fu_ctrl;
    import mem_fu_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int TW   = 5;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dm_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          exc;
    } cd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    dm_t  dm_q[$];
    cd_t  cd_q[$];

    always #5 clk = ~clk;

    mem_fu_ctrl_if #(.XLEN(XLEN), .ROB_TAG_W(TW)) bus ();

    mem_fu_ctrl #(.XLEN(XLEN), .ROB_TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void chk(string nm, logic [71:0] act, logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Monitor: compare each completed memory access and each granted CDB broadcast
    initial begin
        dm_t de;
        cd_t ce;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dmem_resp && ((bus.dmem_rmask != 4'b0) || (bus.dmem_wmask != 4'b0))) begin
                    if (dm_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL dmem_unexpected actual=%h required=none", bus.dmem_addr);
                    end else begin
                        de = dm_q.pop_front();
                        chk("dmem_txn", 72'({bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, bus.dmem_wdata}), 72'(de));
                    end
                end
                if (bus.cdb_req && bus.cdb_gnt) begin
                    if (cd_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cdb_unexpected actual=%h required=none", bus.cdb_rob_tag);
                    end else begin
                        ce = cd_q.pop_front();
                        chk("cdb_txn", 72'({bus.cdb_rob_tag, bus.cdb_data, bus.cdb_exc}), 72'(ce));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic ls, input logic [2:0] op, input logic [31:0] rs1,
                             input logic [31:0] off, input logic [31:0] rs2, input logic [TW-1:0] tag);
        bus.req_ls      = ls;
        bus.req_mem_op  = op;
        bus.req_rs1     = rs1;
        bus.req_offset  = off;
        bus.req_rs2     = rs2;
        bus.req_rob_tag = tag;
        bus.req_valid   = 1'b1;
    endtask

    // Full transaction: accept, memory access after rdly wait cycles, CDB grant after gdly cycles
    task automatic run_op(input string nm, input logic ls, input logic [2:0] op,
                          input logic [31:0] rs1, input logic [31:0] off, input logic [31:0] rs2,
                          input logic [TW-1:0] tag, input logic [31:0] rdata, input int rdly, input int gdly,
                          input logic [31:0] eaddr, input logic [3:0] erm, input logic [3:0] ewm,
                          input logic [31:0] ewd, input logic [31:0] edata);
        chk({nm, "_bp_before"}, 72'(bus.backpressure), 72'(0));
        drive_req(ls, op, rs1, off, rs2, tag);
        dm_q.push_back('{eaddr, erm, ewm, ewd});
        cd_q.push_back('{tag, edata, 1'b0});
        tick();
        bus.req_valid = 1'b0;
        chk({nm, "_bp_access"}, 72'(bus.backpressure), 72'(1));
        chk({nm, "_dmem_req"}, 72'({bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, bus.dmem_wdata}),
            72'({eaddr, erm, ewm, ewd}));
        for (int i = 0; i < rdly; i++) begin
            tick();
            chk({nm, "_dmem_hold"}, 72'({bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, bus.dmem_wdata}),
                72'({eaddr, erm, ewm, ewd}));
        end
        bus.dmem_rdata = rdata;
        bus.dmem_resp  = 1'b1;
        tick();
        bus.dmem_resp  = 1'b0;
        chk({nm, "_dmem_clear"}, 72'({bus.dmem_rmask, bus.dmem_wmask}), 72'(0));
        chk({nm, "_cdb_req"}, 72'({bus.cdb_req, bus.backpressure}), 72'(2'b11));
        chk({nm, "_cdb_val"}, 72'({bus.cdb_rob_tag, bus.cdb_data}), 72'({tag, edata}));
        for (int i = 0; i < gdly; i++) begin
            drive_req(IS_LOAD, MEM_LW, 32'h0000_7000, 32'h0, 32'h0, tag + 5'd1);
            tick();
            chk({nm, "_wb_hold"}, 72'({bus.cdb_req, bus.backpressure, bus.cdb_rob_tag, bus.cdb_data}),
                72'({2'b11, tag, edata}));
        end
        bus.req_valid = 1'b0;
        bus.cdb_gnt   = 1'b1;
        tick();
        bus.cdb_gnt   = 1'b0;
        chk({nm, "_idle_after"}, 72'({bus.cdb_req, bus.backpressure}), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_ls = 1'b0; bus.req_mem_op = 3'd0;
        bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_offset = '0; bus.req_rob_tag = '0;
        bus.dmem_rdata = '0; bus.dmem_resp = 1'b0; bus.cdb_gnt = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dmem", 72'({bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, bus.dmem_wdata}), 72'(0));
        chk("reset_cdb", 72'({bus.backpressure, bus.cdb_req, bus.cdb_rob_tag, bus.cdb_data, bus.cdb_exc}), 72'(0));
        rst_n = 1'b1;
        tick();

        run_op("lw",  IS_LOAD,  MEM_LW,  32'h1000, 32'd4, 32'h0, 5'd3, 32'hDEADBEEF, 0, 0,
               32'h1004, 4'b1111, 4'b0000, 32'h0, 32'hDEADBEEF);
        run_op("lb",  IS_LOAD,  MEM_LB,  32'h1000, 32'd3, 32'h0, 5'd4, 32'h80FF_FFFF, 0, 0,
               32'h1000, 4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF80);
        run_op("lbu", IS_LOAD,  MEM_LBU, 32'h1000, 32'd3, 32'h0, 5'd5, 32'h80FF_FFFF, 1, 0,
               32'h1000, 4'b1000, 4'b0000, 32'h0, 32'h0000_0080);
        run_op("lh",  IS_LOAD,  MEM_LH,  32'h0100, 32'd2, 32'h0, 5'd6, 32'h8001_0000, 0, 1,
               32'h0100, 4'b1100, 4'b0000, 32'h0, 32'hFFFF_8001);
        run_op("lhu", IS_LOAD,  MEM_LHU, 32'h0200, 32'd0, 32'h0, 5'd7, 32'h1234_F00D, 0, 0,
               32'h0200, 4'b0011, 4'b0000, 32'h0, 32'h0000_F00D);
        run_op("sh",  IS_STORE, MEM_SH,  32'h2000, 32'd2, 32'h1234_ABCD, 5'd8, 32'hFFFF_FFFF, 0, 0,
               32'h2000, 4'b0000, 4'b1100, 32'hABCD_0000, 32'h0);
        run_op("sb",  IS_STORE, MEM_SB,  32'h5000, 32'd1, 32'h0000_00AB, 5'd9, 32'h0, 0, 0,
               32'h5000, 4'b0000, 4'b0010, 32'h0000_AB00, 32'h0);
        run_op("sw_gntwait", IS_STORE, MEM_SW, 32'h0040, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd10, 32'h0, 0, 3,
               32'h003C, 4'b0000, 4'b1111, 32'hCAFE_F00D, 32'h0);

        // Flush in IDLE blocks acceptance; a stray dmem_resp in IDLE is ignored
        drive_req(IS_LOAD, MEM_LW, 32'h3000, 32'h0, 32'h0, 5'd11);
        bus.flush = 1'b1;
        bus.dmem_resp = 1'b1;
        tick();
        bus.req_valid = 1'b0; bus.flush = 1'b0; bus.dmem_resp = 1'b0;
        chk("flush_idle_bp", 72'({bus.backpressure, bus.dmem_rmask}), 72'(0));

        // Flush in ACCESS: request held until the late response, then IDLE with no CDB request
        drive_req(IS_LOAD, MEM_LW, 32'h3000, 32'h8, 32'h0, 5'd12);
        dm_q.push_back('{32'h3008, 4'b1111, 4'b0000, 32'h0});
        tick();
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("drain_hold1", 72'({bus.backpressure, bus.dmem_addr, bus.dmem_rmask}), 72'({1'b1, 32'h3008, 4'b1111}));
        tick();
        chk("drain_hold2", 72'({bus.backpressure, bus.dmem_addr, bus.dmem_rmask}), 72'({1'b1, 32'h3008, 4'b1111}));
        bus.dmem_rdata = 32'h5555_5555;
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("drain_done", 72'({bus.backpressure, bus.cdb_req, bus.dmem_rmask}), 72'(0));

        // Flush together with the response in ACCESS goes straight to IDLE
        drive_req(IS_STORE, MEM_SW, 32'h3100, 32'h0, 32'h1111_2222, 5'd13);
        dm_q.push_back('{32'h3100, 4'b0000, 4'b1111, 32'h1111_2222});
        tick();
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        bus.dmem_resp = 1'b1;
        tick();
        bus.flush = 1'b0; bus.dmem_resp = 1'b0;
        chk("flush_resp_idle", 72'({bus.backpressure, bus.cdb_req, bus.dmem_wmask}), 72'(0));

        // Flush in WB drops the pending result
        drive_req(IS_LOAD, MEM_LW, 32'h3200, 32'h0, 32'h0, 5'd14);
        dm_q.push_back('{32'h3200, 4'b1111, 4'b0000, 32'h0});
        tick();
        bus.req_valid = 1'b0;
        bus.dmem_rdata = 32'h0BAD_0BAD;
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
        chk("wb_before_flush", 72'(bus.cdb_req), 72'(1));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("wb_flush_drop", 72'({bus.cdb_req, bus.backpressure}), 72'(0));

        // Reset mid-access returns to IDLE at once with memory outputs cleared
        drive_req(IS_LOAD, MEM_LW, 32'h3300, 32'h0, 32'h0, 5'd15);
        tick();
        bus.req_valid = 1'b0;
        chk("pre_reset_busy", 72'(bus.backpressure), 72'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 72'({bus.backpressure, bus.dmem_addr, bus.dmem_rmask, bus.cdb_req}), 72'(0));
        tick();
        rst_n = 1'b1;
        tick();

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word traps without touching memory
        drive_req(IS_LOAD, MEM_LW, 32'h1000, 32'd2, 32'h0, 5'd16);
        cd_q.push_back('{5'd16, 32'h1002, 1'b1});
        tick();
        bus.req_valid = 1'b0;
        chk("trap_no_dmem", 72'({bus.dmem_rmask, bus.dmem_wmask}), 72'(0));
        chk("trap_cdb", 72'({bus.cdb_req, bus.cdb_exc, bus.cdb_data}), 72'({2'b11, 32'h1002}));
        bus.cdb_gnt = 1'b1;
        tick();
        bus.cdb_gnt = 1'b0;
        chk("trap_idle", 72'(bus.backpressure), 72'(0));
`endif

        tick();
        chk("dm_queue_empty", 72'(dm_q.size()), 72'(0));
        chk("cd_queue_empty", 72'(cd_q.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
